// File: rtl/noise_pkg.sv
// Shared constants and lookup tables for the APU noise voice and its envelope.
package noise_pkg;

   localparam logic [3:0] ENV_MAX = 4'hF;
   localparam int         VOL_W   = 4;

   function automatic logic [7:0] length_lut(input logic [4:0] idx);
      logic [7:0] len;
      case (idx)
         5'd0:  len = 8'h0A;  5'd1:  len = 8'hFE;  5'd2:  len = 8'h14;  5'd3:  len = 8'h02;
         5'd4:  len = 8'h28;  5'd5:  len = 8'h04;  5'd6:  len = 8'h50;  5'd7:  len = 8'h06;
         5'd8:  len = 8'hA0;  5'd9:  len = 8'h08;  5'd10: len = 8'h3C;  5'd11: len = 8'h0A;
         5'd12: len = 8'h0E;  5'd13: len = 8'h0C;  5'd14: len = 8'h1A;  5'd15: len = 8'h0E;
         5'd16: len = 8'h0C;  5'd17: len = 8'h10;  5'd18: len = 8'h18;  5'd19: len = 8'h12;
         5'd20: len = 8'h30;  5'd21: len = 8'h14;  5'd22: len = 8'h60;  5'd23: len = 8'h16;
         5'd24: len = 8'hC0;  5'd25: len = 8'h18;  5'd26: len = 8'h48;  5'd27: len = 8'h1A;
         5'd28: len = 8'h10;  5'd29: len = 8'h1C;  5'd30: len = 8'h20;  default: len = 8'h1E;
      endcase
      return len;
   endfunction

   function automatic logic [11:0] noise_period_lut(input logic [3:0] idx);
      logic [11:0] per;
      case (idx)
         4'd0:  per = 12'h004;  4'd1:  per = 12'h008;  4'd2:  per = 12'h010;  4'd3:  per = 12'h020;
         4'd4:  per = 12'h040;  4'd5:  per = 12'h060;  4'd6:  per = 12'h080;  4'd7:  per = 12'h0A0;
         4'd8:  per = 12'h0CA;  4'd9:  per = 12'h0FE;  4'd10: per = 12'h17C;  4'd11: per = 12'h1FC;
         4'd12: per = 12'h2FA;  4'd13: per = 12'h3F8;  4'd14: per = 12'h7F2;  default: per = 12'hFE4;
      endcase
      return per;
   endfunction

endpackage

// File: rtl/apu_envelope.sv
// Decaying envelope (start flag, divider, loop) shared by the noise and pulse voices.
// Volume is combinational from the decay register; restart is a sticky request.
module apu_envelope
   import noise_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             quarter_frame,
   input  logic             restart,
   input  logic             loop,
   input  logic             const_vol,
   input  logic [3:0]       param,
   output logic [VOL_W-1:0] volume
);

   logic       start_q, start_d;
   logic [3:0] divider_q, divider_d;
   logic [3:0] decay_q, decay_d;

   always_comb begin
      start_d   = start_q;
      divider_d = divider_q;
      decay_d   = decay_q;
      if (quarter_frame) begin
         if (start_q) begin
            start_d   = 1'b0;
            decay_d   = ENV_MAX;
            divider_d = param;
         end else if (divider_q == 4'd0) begin
            divider_d = param;
            if (decay_q != 4'd0) decay_d = decay_q - 4'd1;
            else if (loop)       decay_d = ENV_MAX;
         end else begin
            divider_d = divider_q - 4'd1;
         end
      end
      // A restart landing on a quarter frame is held for the following one.
      if (restart) start_d = 1'b1;
      volume = const_vol ? param : decay_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         start_q   <= 1'b0;
         divider_q <= 4'd0;
         decay_q   <= 4'd0;
      end else begin
         start_q   <= start_d;
         divider_q <= divider_d;
         decay_q   <= decay_d;
      end
   end

endmodule

// File: rtl/noise_channel_env.sv
// APU noise voice: table-driven timer clocking an LFSR, envelope, length counter, enable gate.
// Sample and length status are registered one cycle behind the internal state.
module noise_channel_env
   import noise_pkg::*;
#(
   parameter int TIMER_W   = 12,
   parameter int LFSR_W    = 15,
   parameter int TAP_LONG  = 1,
   parameter int TAP_SHORT = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             quarter_frame,
   input  logic             half_frame,
   input  logic             channel_enable,
   input  logic [7:0]       reg_400C,
   input  logic [7:0]       reg_400E,
   input  logic [7:0]       reg_400F,
   input  logic             reg_event,
   output logic [VOL_W-1:0] noise_out,
   output logic             length_active
);

   logic [TIMER_W-1:0] timer_q, timer_d;
   logic               timer_event_q, timer_event_d;
   logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
   logic [7:0]         length_q, length_d;
   logic [VOL_W-1:0]   noise_out_q, noise_out_d;
   logic               length_active_q, length_active_d;
   logic [VOL_W-1:0]   volume;
   logic               fb;
   logic               unused_bits;

   assign unused_bits = ^{reg_400C[7:6], reg_400E[6:4], reg_400F[2:0]};

   apu_envelope u_env (
      .clk           (clk),
      .rst_n         (rst_n),
      .quarter_frame (quarter_frame),
      .restart       (reg_event),
      .loop          (reg_400C[5]),
      .const_vol     (reg_400C[4]),
      .param         (reg_400C[3:0]),
      .volume        (volume)
   );

   always_comb begin
      timer_d       = (timer_q == '0) ? TIMER_W'(noise_period_lut(reg_400E[3:0]))
                                      : timer_q - TIMER_W'(1);
      timer_event_d = (timer_q == '0);

      fb     = lfsr_q[0] ^ (reg_400E[7] ? lfsr_q[TAP_SHORT] : lfsr_q[TAP_LONG]);
      lfsr_d = lfsr_q;
      if (timer_event_q)        lfsr_d = {fb, lfsr_q[LFSR_W-1:1]};
      else if (lfsr_q == '0)    lfsr_d = LFSR_W'(1);

      // Disable dominates, then a length load beats a same-cycle half-frame decrement.
      length_d = length_q;
      if (!channel_enable)
         length_d = 8'd0;
      else if (reg_event)
         length_d = length_lut(reg_400F[7:3]);
      else if (half_frame && (length_q != 8'd0) && !reg_400C[5])
         length_d = length_q - 8'd1;

      noise_out_d     = ((length_q == 8'd0) || lfsr_q[0]) ? '0 : volume;
      length_active_d = (length_q != 8'd0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         timer_q         <= '0;
         timer_event_q   <= 1'b0;
         lfsr_q          <= LFSR_W'(1);
         length_q        <= 8'd0;
         noise_out_q     <= '0;
         length_active_q <= 1'b0;
      end else begin
         timer_q         <= timer_d;
         timer_event_q   <= timer_event_d;
         lfsr_q          <= lfsr_d;
         length_q        <= length_d;
         noise_out_q     <= noise_out_d;
         length_active_q <= length_active_d;
      end
   end

   assign noise_out     = noise_out_q;
   assign length_active = length_active_q;

endmodule

// File: tb/tb_noise_channel_env.sv
// Directed bench for the noise voice: LFSR stepping, envelope, length counter, reset.
module tb_noise_channel_env;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       quarter_frame, half_frame, channel_enable, reg_event;
   logic [7:0] reg_400C, reg_400E, reg_400F;
   logic [3:0] noise_out, noise_out7;
   logic       length_active, length_active7;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   noise_channel_env dut (
      .clk(clk), .rst_n(rst_n), .quarter_frame(quarter_frame), .half_frame(half_frame),
      .channel_enable(channel_enable), .reg_400C(reg_400C), .reg_400E(reg_400E),
      .reg_400F(reg_400F), .reg_event(reg_event), .noise_out(noise_out),
      .length_active(length_active)
   );

   noise_channel_env #(.LFSR_W(7), .TAP_SHORT(1)) dut7 (
      .clk(clk), .rst_n(rst_n), .quarter_frame(quarter_frame), .half_frame(half_frame),
      .channel_enable(channel_enable), .reg_400C(reg_400C), .reg_400E(reg_400E),
      .reg_400F(reg_400F), .reg_event(reg_event), .noise_out(noise_out7),
      .length_active(length_active7)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic pulse_qf();
      quarter_frame = 1'b1; tick(); quarter_frame = 1'b0;
   endtask

   task automatic pulse_hf();
      half_frame = 1'b1; tick(); half_frame = 1'b0;
   endtask

   task automatic pulse_ev();
      reg_event = 1'b1; tick(); reg_event = 1'b0;
   endtask

   initial begin
      logic [14:0] prev15;
      logic [6:0]  prev7;
      int          n15, n7, bad;
      bit          done15, done7;

      rst_n = 1'b0; quarter_frame = 0; half_frame = 0; channel_enable = 0; reg_event = 0;
      reg_400C = 8'h00; reg_400E = 8'h00; reg_400F = 8'h00;
      tick(); tick();
      chk("rst_noise_out", 32'(noise_out), 0);
      chk("rst_length_active", 32'(length_active), 0);
      chk("rst_lfsr", 32'(dut.lfsr_q), 1);
      chk("rst_length", 32'(dut.length_q), 0);

      // LFSR mode 0 stepping, period index 0
      rst_n = 1'b1; channel_enable = 1'b1; reg_400F = 8'h08; reg_event = 1'b1;
      tick(); reg_event = 1'b0;
      chk("lfsr_step0", 32'(dut.lfsr_q), 32'h0001);
      chk("len_load_254", 32'(dut.length_q), 254);
      tick();
      chk("lfsr_step1", 32'(dut.lfsr_q), 32'h4000);
      repeat (5) tick();
      chk("lfsr_step2", 32'(dut.lfsr_q), 32'h2000);
      repeat (5) tick();
      chk("lfsr_step3", 32'(dut.lfsr_q), 32'h1000);

      // Mode 1 period from the reset seed, both builds
      rst_n = 1'b0; reg_400E = 8'h80; tick();
      rst_n = 1'b1;
      prev15 = 15'd1; prev7 = 7'd1; n15 = 0; n7 = 0; done15 = 0; done7 = 0;
      for (int c = 0; c < 1500 && !(done15 && done7); c++) begin
         tick();
         if (!done15 && dut.lfsr_q != prev15) begin
            n15++; prev15 = dut.lfsr_q;
            if (prev15 == 15'd1) done15 = 1;
         end
         if (!done7 && dut7.lfsr_q != prev7) begin
            n7++; prev7 = dut7.lfsr_q;
            if (prev7 == 7'd1) done7 = 1;
         end
      end
      chk("mode1_period_w15", done15 ? n15 : -1, 93);
      chk("mode1_period_w7", done7 ? n7 : -1, 127);

      // Envelope: restart coinciding with a quarter frame is held
      reg_400E = 8'h00; reg_400C = 8'h03;
      reg_event = 1'b1; quarter_frame = 1'b1; tick(); reg_event = 1'b0; quarter_frame = 1'b0;
      chk("env_start_held", 32'(dut.u_env.start_q), 1);
      chk("env_vol_before_qf", 32'(dut.u_env.volume), 0);
      for (int q = 1; q <= 65; q++) begin
         pulse_qf();
         if (q == 1)  chk("env_qf1", 32'(dut.u_env.volume), 15);
         if (q == 5)  chk("env_qf5", 32'(dut.u_env.volume), 14);
         if (q == 61) chk("env_qf61", 32'(dut.u_env.volume), 0);
         if (q == 65) chk("env_qf65", 32'(dut.u_env.volume), 0);
      end
      reg_400C = 8'h23; pulse_ev();
      for (int q = 1; q <= 65; q++) begin
         pulse_qf();
         if (q == 61) chk("env_loop_qf61", 32'(dut.u_env.volume), 0);
         if (q == 65) chk("env_loop_qf65", 32'(dut.u_env.volume), 15);
      end

      // Length counter with constant volume A
      reg_400C = 8'h1A; reg_400F = 8'h08; pulse_ev(); tick();
      chk("len_active_on", 32'(length_active), 1);
      chk("len_254", 32'(dut.length_q), 254);
      bad = 0;
      for (int c = 0; c < 60; c++) begin
         tick();
         if (noise_out != 4'h0 && noise_out != 4'hA) bad++;
      end
      chk("noise_out_0_or_A", bad, 0);
      repeat (253) pulse_hf();
      tick();
      chk("len_after_253", 32'(dut.length_q), 1);
      chk("len_active_after_253", 32'(length_active), 1);
      pulse_hf(); tick();
      chk("len_active_after_254", 32'(length_active), 0);
      chk("noise_out_after_254", 32'(noise_out), 0);
      pulse_hf();
      chk("len_saturates", 32'(dut.length_q), 0);
      reg_400C = 8'h3A; pulse_ev();
      repeat (10) pulse_hf();
      chk("len_halt_hold", 32'(dut.length_q), 254);

      // Channel enable and load priority
      reg_400C = 8'h1A;
      channel_enable = 1'b0; tick();
      chk("len_disable", 32'(dut.length_q), 0);
      pulse_ev();
      chk("len_ev_while_disabled", 32'(dut.length_q), 0);
      channel_enable = 1'b1;
      reg_event = 1'b1; half_frame = 1'b1; tick(); reg_event = 1'b0; half_frame = 1'b0;
      chk("len_ev_hf_preset", 32'(dut.length_q), 254);
      reg_400F = 8'hF8;
      reg_event = 1'b1; half_frame = 1'b1; tick(); reg_event = 1'b0; half_frame = 1'b0;
      chk("len_ev_hf_idx31", 32'(dut.length_q), 32'h1E);

      // Reset mid-decay and mid-length
      reg_400C = 8'h03; pulse_ev();
      repeat (6) pulse_qf();
      chk("pre_rst_vol", 32'(dut.u_env.volume), 14);
      rst_n = 1'b0; tick();
      chk("rst2_vol", 32'(dut.u_env.volume), 0);
      chk("rst2_start", 32'(dut.u_env.start_q), 0);
      chk("rst2_divider", 32'(dut.u_env.divider_q), 0);
      chk("rst2_length", 32'(dut.length_q), 0);
      chk("rst2_lfsr", 32'(dut.lfsr_q), 1);
      chk("rst2_timer", 32'(dut.timer_q), 0);
      chk("rst2_timer_event", 32'(dut.timer_event_q), 0);
      chk("rst2_noise_out", 32'(noise_out), 0);
      chk("rst2_length_active", 32'(length_active), 0);
      rst_n = 1'b1; tick();
      chk("post_rst_lfsr", 32'(dut.lfsr_q), 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
